// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between instruction fetch (IF) and the execute-stage
// load/store unit (LS). At most one requester is granted per cycle, and the
// request path to memory is combinational. Read data returns MEM_LAT cycles
// after the grant. A tag pipeline follows each access so that its response
// goes back to the requester that issued it. A streak counter limits how long
// LS can starve a waiting fetch.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   if_req_i        fetch request, held until if_gnt_o
//   if_addr_i       fetch address
//   if_gnt_o        fetch accepted this cycle
//   if_rvalid_o     fetch data valid
//   if_rdata_o      fetch data (0 when not valid)
//   flush_i         discard every in-flight fetch response
//   ls_req_i        load/store request, held until ls_gnt_o
//   ls_we_i         1 = store
//   ls_addr_i       load/store address
//   ls_wdata_i      store data
//   ls_wmask_i      store byte mask
//   ls_gnt_o        load/store accepted this cycle
//   ls_rvalid_o     load/store completion
//   ls_rdata_o      load data (0 for stores and when not valid)
//   hold_flag_o     LS pending but not granted (pipeline stall)
//   mem_req_o       memory access this cycle
//   mem_we_o        memory write enable
//   mem_addr_o      memory address
//   mem_wdata_o     memory write data
//   mem_wmask_o     memory write mask
//   mem_rdata_i     memory read data, MEM_LAT cycles after the access
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 1,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              flush_i,
    input  logic              ls_req_i,
    input  logic              ls_we_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [DATA_W-1:0] ls_wdata_i,
    input  logic [3:0]        ls_wmask_i,
    output logic              ls_gnt_o,
    output logic              ls_rvalid_o,
    output logic [DATA_W-1:0] ls_rdata_o,
    output logic              hold_flag_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam logic [3:0] LP_MAX_STREAK = 4'(MAX_LS_STREAK);

    typedef enum logic {
        LS_PRIO = 1'b0,
        IF_PRIO = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_streak;
    logic [3:0]         w_streak_nxt;
    logic               w_if_gnt;
    logic               w_ls_gnt;
    logic               w_out_vld;

    // Tag pipeline: index 0 is loaded by the current grant and
    // index MEM_LAT-1 lines up with mem_rdata_i.
    logic [MEM_LAT-1:0] r_tag_vld;
    logic [MEM_LAT-1:0] r_tag_ls;
    logic [MEM_LAT-1:0] r_tag_st;

    // Grant selection and next-state logic. Grants are masked during reset
    // so that every output reads 0 while rst is high.
    always_comb begin
        w_if_gnt     = 1'b0;
        w_ls_gnt     = 1'b0;
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;

        if (!rst) begin
            if (if_req_i && ls_req_i) begin
                if (r_state == IF_PRIO) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_ls_gnt = 1'b1;
                end
            end else if (if_req_i) begin
                w_if_gnt = 1'b1;
            end else if (ls_req_i) begin
                w_ls_gnt = 1'b1;
            end
        end

        // The streak counts only LS grants that make a fetch wait. A served
        // or withdrawn fetch ends the streak and returns to LS priority.
        if (w_if_gnt || !if_req_i) begin
            w_streak_nxt = 4'd0;
            w_state_nxt  = LS_PRIO;
        end else if (w_ls_gnt) begin
            w_streak_nxt = r_streak + 4'd1;
            if ((r_state == LS_PRIO) && ((r_streak + 4'd1) == LP_MAX_STREAK)) begin
                w_state_nxt = IF_PRIO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LS_PRIO;
            r_streak <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Stage boundary: grant -> tag pipeline. A flush kills IF-owned entries
    // as they move forward. An entry issued in the flush cycle enters
    // untouched, because it was granted after the redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_ls  <= '0;
            r_tag_st  <= '0;
        end else begin
            r_tag_vld[0] <= w_if_gnt | w_ls_gnt;
            r_tag_ls[0]  <= w_ls_gnt;
            r_tag_st[0]  <= w_ls_gnt & ls_we_i;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1] & ~(flush_i & ~r_tag_ls[i-1]);
                r_tag_ls[i]  <= r_tag_ls[i-1];
                r_tag_st[i]  <= r_tag_st[i-1];
            end
        end
    end

    // Stage boundary: final tag stage -> response outputs. A flush also
    // suppresses the fetch response presented in the same cycle.
    assign w_out_vld   = r_tag_vld[MEM_LAT-1] & ~rst;
    assign if_rvalid_o = w_out_vld & ~r_tag_ls[MEM_LAT-1] & ~flush_i;
    assign ls_rvalid_o = w_out_vld & r_tag_ls[MEM_LAT-1];
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign ls_rdata_o  = (ls_rvalid_o && !r_tag_st[MEM_LAT-1]) ? mem_rdata_i : '0;

    assign if_gnt_o    = w_if_gnt;
    assign ls_gnt_o    = w_ls_gnt;
    assign hold_flag_o = ls_req_i & ~w_ls_gnt & ~rst;

    assign mem_req_o   = w_if_gnt | w_ls_gnt;
    assign mem_we_o    = w_ls_gnt & ls_we_i;
    assign mem_addr_o  = w_ls_gnt ? ls_addr_i : (w_if_gnt ? if_addr_i : '0);
    assign mem_wdata_o = w_ls_gnt ? ls_wdata_i : '0;
    assign mem_wmask_o = w_ls_gnt ? ls_wmask_i : 4'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          flush_i;
    logic          ls_req_i;
    logic          ls_we_i;
    logic [AW-1:0] ls_addr_i;
    logic [DW-1:0] ls_wdata_i;
    logic [3:0]    ls_wmask_i;
    logic          ls_gnt_o;
    logic          ls_rvalid_o;
    logic [DW-1:0] ls_rdata_o;
    logic          hold_flag_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_wmask_o;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_LS_STREAK(MAXS)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .flush_i(flush_i),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_wmask_i(ls_wmask_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .hold_flag_o(hold_flag_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: priority turn, streak length, and a calendar of
    // expected responses indexed by the cycle they are due.
    bit m_if_turn;
    int m_streak;
    bit rq_v [8];
    bit rq_ls[8];
    bit rq_st[8];
    bit m_if_gnt;
    bit m_ls_gnt;

    typedef struct {
        logic ifr;
        logic lsr;
        logic e_if;
        logic e_ls;
        logic e_hold;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Evaluate one cycle: settle, predict, compare, advance the model.
    task automatic step();
        bit          eif_rv;
        bit          els_rv;
        logic [31:0] eif_rd;
        logic [31:0] els_rd;
        int          s;
        #1;
        m_if_gnt = 1'b0;
        m_ls_gnt = 1'b0;
        eif_rv   = 1'b0;
        els_rv   = 1'b0;
        eif_rd   = '0;
        els_rd   = '0;
        if (rst) begin
            for (int k = 0; k < 8; k++) rq_v[k] = 1'b0;
            m_if_turn = 1'b0;
            m_streak  = 0;
        end else begin
            if (if_req_i && ls_req_i) begin
                if (m_if_turn) m_if_gnt = 1'b1;
                else           m_ls_gnt = 1'b1;
            end else begin
                m_if_gnt = if_req_i;
                m_ls_gnt = ls_req_i;
            end
            if (flush_i) begin
                for (int k = 0; k < LAT; k++) begin
                    s = (cyc + k) % 8;
                    if (!rq_ls[s]) rq_v[s] = 1'b0;
                end
            end
            s      = cyc % 8;
            eif_rv = rq_v[s] && !rq_ls[s];
            els_rv = rq_v[s] && rq_ls[s];
            eif_rd = eif_rv ? mem_rdata_i : 32'd0;
            els_rd = (els_rv && !rq_st[s]) ? mem_rdata_i : 32'd0;
            rq_v[s] = 1'b0;
            s = (cyc + LAT) % 8;
            rq_v[s]  = m_if_gnt || m_ls_gnt;
            rq_ls[s] = m_ls_gnt;
            rq_st[s] = m_ls_gnt && ls_we_i;
            if (m_if_gnt || !if_req_i) begin
                m_streak  = 0;
                m_if_turn = 1'b0;
            end else if (m_ls_gnt) begin
                m_streak++;
                if (m_streak >= MAXS) m_if_turn = 1'b1;
            end
        end
        chk("if_gnt", if_gnt_o, m_if_gnt);
        chk("ls_gnt", ls_gnt_o, m_ls_gnt);
        chk("hold", hold_flag_o, ls_req_i && !m_ls_gnt && !rst);
        chk("mem_req", mem_req_o, m_if_gnt || m_ls_gnt);
        chk("if_rvalid", if_rvalid_o, eif_rv);
        chk("if_rdata", if_rdata_o, eif_rd);
        chk("ls_rvalid", ls_rvalid_o, els_rv);
        chk("ls_rdata", ls_rdata_o, els_rd);
        if (m_if_gnt) begin
            chk("mem_addr_if", mem_addr_o, if_addr_i);
            chk("mem_we_if", mem_we_o, 0);
        end
        if (m_ls_gnt) begin
            chk("mem_addr_ls", mem_addr_o, ls_addr_i);
            chk("mem_we_ls", mem_we_o, ls_we_i);
            chk("mem_wdata", mem_wdata_o, ls_wdata_i);
            chk("mem_wmask", mem_wmask_o, ls_wmask_i);
        end
        if (rst) begin
            chk("rst_mem_we", mem_we_o, 0);
            chk("rst_mem_addr", mem_addr_o, 0);
            chk("rst_mem_wdata", mem_wdata_o, 0);
            chk("rst_mem_wmask", mem_wmask_o, 0);
        end
        cyc++;
    endtask

    task automatic idle();
        if_req_i = 1'b0;
        ls_req_i = 1'b0;
        flush_i  = 1'b0;
        ls_we_i  = 1'b0;
    endtask

    task automatic drain(input int n);
        idle();
        for (int i = 0; i < n; i++) begin
            mem_rdata_i = $urandom;
            step();
            @(negedge clk);
        end
    endtask

    initial begin
        bit ifp;
        bit lsp;

        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            else                  tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        end

        rst = 1'b1;
        idle();
        if_addr_i   = '0;
        ls_addr_i   = '0;
        ls_wdata_i  = '0;
        ls_wmask_i  = '0;
        mem_rdata_i = '0;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_if_gnt", if_gnt_o, 0);
            chk("rst_ls_rvalid", ls_rvalid_o, 0);
            @(negedge clk);
        end
        rst = 1'b0;

        // Single load at 0x100
        ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h100; ls_wmask_i = 4'hF;
        step();
        chk("t1_gnt", ls_gnt_o, 1);
        chk("t1_hold", hold_flag_o, 0);
        @(negedge clk);
        idle();
        step();
        chk("t1_early_rv", ls_rvalid_o, 0);
        @(negedge clk);
        mem_rdata_i = 32'hDEADBEEF;
        step();
        chk("t1_rv", ls_rvalid_o, 1);
        chk("t1_rd", ls_rdata_o, 32'hDEADBEEF);
        @(negedge clk);

        // Store
        ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h300;
        ls_wdata_i = 32'h1234ABCD; ls_wmask_i = 4'b0011;
        step();
        chk("st_we", mem_we_o, 1);
        chk("st_wmask", mem_wmask_o, 4'b0011);
        chk("st_wdata", mem_wdata_o, 32'h1234ABCD);
        @(negedge clk);
        idle();
        drain(1);
        mem_rdata_i = 32'hFFFFFFFF;
        step();
        chk("st_rv", ls_rvalid_o, 1);
        chk("st_rd", ls_rdata_o, 0);
        @(negedge clk);

        // Contention table
        if_addr_i = 32'h1000;
        ls_we_i   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if_req_i    = tbl[i].ifr;
            ls_req_i    = tbl[i].lsr;
            ls_addr_i   = 32'h2000 + 32'(4 * i);
            mem_rdata_i = $urandom;
            step();
            chk("ct_if_gnt", if_gnt_o, tbl[i].e_if);
            chk("ct_ls_gnt", ls_gnt_o, tbl[i].e_ls);
            chk("ct_hold", hold_flag_o, tbl[i].e_hold);
            @(negedge clk);
        end
        drain(LAT + 1);

        // Interleaved IF / LS load
        for (int k = 0; k < 10; k++) begin
            if_req_i    = (k % 2 == 0) && (k < 8);
            ls_req_i    = (k % 2 == 1) && (k < 8);
            if_addr_i   = 32'h0;
            ls_addr_i   = 32'h200;
            ls_we_i     = 1'b0;
            mem_rdata_i = $urandom;
            step();
            chk("il_excl", if_rvalid_o & ls_rvalid_o, 0);
            chk("il_if_rv", if_rvalid_o, (k >= LAT) && ((k - LAT) % 2 == 0));
            chk("il_ls_rv", ls_rvalid_o, (k >= LAT) && ((k - LAT) % 2 == 1));
            @(negedge clk);
        end
        drain(LAT);

        // Flush with two fetches in flight
        if_req_i = 1'b1; if_addr_i = 32'h40;
        step(); @(negedge clk);
        if_addr_i = 32'h44;
        step(); @(negedge clk);
        idle(); flush_i = 1'b1; mem_rdata_i = 32'h11111111;
        step();
        chk("fl_a_rv0", if_rvalid_o, 0);
        @(negedge clk);
        flush_i = 1'b0; mem_rdata_i = 32'h22222222;
        step();
        chk("fl_a_rv1", if_rvalid_o, 0);
        @(negedge clk);

        // Flush with a load in flight
        if_req_i = 1'b1; if_addr_i = 32'h48;
        step(); @(negedge clk);
        idle(); ls_req_i = 1'b1; ls_addr_i = 32'h500;
        step(); @(negedge clk);
        idle(); flush_i = 1'b1;
        step();
        chk("fl_b_if_rv", if_rvalid_o, 0);
        @(negedge clk);
        flush_i = 1'b0; mem_rdata_i = 32'hCAFEF00D;
        step();
        chk("fl_b_ls_rv", ls_rvalid_o, 1);
        chk("fl_b_ls_rd", ls_rdata_o, 32'hCAFEF00D);
        @(negedge clk);

        // Fetch granted in the flush cycle survives
        if_req_i = 1'b1; if_addr_i = 32'h80; flush_i = 1'b1;
        step(); @(negedge clk);
        idle();
        drain(1);
        mem_rdata_i = 32'h0BADF00D;
        step();
        chk("fl_c_rv", if_rvalid_o, 1);
        chk("fl_c_rd", if_rdata_o, 32'h0BADF00D);
        @(negedge clk);

        // Reset with two loads outstanding and a partial streak
        if_req_i = 1'b1; ls_req_i = 1'b1; if_addr_i = 32'h3000; ls_we_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ls_addr_i = 32'h600 + 32'(4 * i);
            step(); @(negedge clk);
        end
        idle(); rst = 1'b1; mem_rdata_i = 32'hAAAAAAAA;
        step();
        chk("mr_ls_rv", ls_rvalid_o, 0);
        chk("mr_mem_req", mem_req_o, 0);
        chk("mr_hold", hold_flag_o, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rdata_i = 32'hBBBBBBBB;
            step();
            chk("mr_after_rv", ls_rvalid_o, 0);
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            if_req_i = 1'b1; ls_req_i = 1'b1; ls_addr_i = 32'h700 + 32'(4 * i);
            step();
            chk("mr_if_gnt", if_gnt_o, tbl[i].e_if);
            chk("mr_ls_gnt", ls_gnt_o, tbl[i].e_ls);
            @(negedge clk);
        end
        drain(LAT + 1);

        // Randomized traffic against the model
        ifp = 1'b0;
        lsp = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (!ifp && $urandom_range(0, 2) != 0) begin
                ifp       = 1'b1;
                if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsp && $urandom_range(0, 2) != 0) begin
                lsp        = 1'b1;
                ls_we_i    = $urandom_range(0, 1);
                ls_addr_i  = $urandom;
                ls_wdata_i = $urandom;
                ls_wmask_i = 4'($urandom_range(0, 15));
            end
            if_req_i    = ifp;
            ls_req_i    = lsp;
            flush_i     = ($urandom_range(0, 7) == 0);
            mem_rdata_i = $urandom;
            step();
            if (m_if_gnt) ifp = 1'b0;
            if (m_ls_gnt) lsp = 1'b0;
            @(negedge clk);
        end
        drain(LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
